// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and default widths for the ALU op sequencer.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_OPW   = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath state; the add itself is done by the external ALU.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             last_iter_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CntW-1:0]  cnt_q;

  assign acc_o      = acc_q;
  assign mcand_o    = mcand_q;
  // sum_i is acc + mcand from the ALU adder; only taken when the current multiplier bit is set.
  assign acc_next_o = mplier_q[0] ? sum_i : acc_q;
  assign last_iter_o = ((mplier_q >> 1) == '0) || (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_next_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for an external 32-bit ALU: request/response handshakes, operand
// muxing, and an iterative MUL that reuses the ALU adder.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [OPW-1:0]   req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic [OPW-1:0]   alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_acc, mul_mcand, mul_acc_next;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (mul_load),
    .step_i     (mul_step),
    .mcand_i    (req_a_i),
    .mplier_i   (req_b_i),
    .sum_i      (alu_result_i),
    .acc_o      (mul_acc),
    .mcand_o    (mul_mcand),
    .acc_next_o (mul_acc_next),
    .last_iter_o(mul_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_result_d = rsp_result_q;
    mul_load     = 1'b0;
    mul_step     = 1'b0;
    alu_sel_o    = '0;
    alu_a_o      = '0;
    alu_b_o      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d = req_op_i;
          a_d  = req_a_i;
          b_d  = req_b_i;
          if (req_op_i == OPW'(OP_MUL)) begin
            mul_load = 1'b1;
            state_d  = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_sel_o    = op_q;
        alu_a_o      = a_q;
        alu_b_o      = b_q;
        rsp_result_d = alu_result_i;
        state_d      = S_DONE;
      end
      S_MUL: begin
        alu_sel_o = OPW'(OP_ADD);
        alu_a_o   = mul_acc;
        alu_b_o   = mul_mcand;
        mul_step  = 1'b1;
        if (mul_last) begin
          rsp_result_d = mul_acc_next;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_valid_o  = (state_q == S_DONE);
  assign rsp_result_o = rsp_result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 32-bit ALU on its select/operand buses.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .WIDTH(W),
    .OPW  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .alu_sel_o   (alu_sel),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_result_i(alu_result),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .busy_o      (busy)
  );

  // Reference ALU driven by the DUT's select/operand buses.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, expected event did not occur", name);
  endtask

  // Monitor: a response is consumed on the next edge whenever valid && ready.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string        nm;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_rsp");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, rsp_result, e);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || !req_ready) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) timeout("wait_idle");
  endtask

  // Issue one op with rsp_ready=1; checks ALU select, busy, latency k and return to idle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int k, input string name);
    int n = 0;
    wait_idle();
    exp_q.push_back(exp);
    name_q.push_back(name);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({name, "_sel"}, W'(alu_sel), (op == OP_MUL) ? W'(OP_ADD) : W'(op));
    check({name, "_busy"}, W'(busy), W'(1));
    check({name, "_rdy_low"}, W'(req_ready), W'(0));
    while (!rsp_valid && n < int'(W) + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, W'(n), W'(k));
    @(posedge clk);
    #1;
    check({name, "_idle_after"}, W'({busy, req_ready}), W'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2;
    check("reset_rsp_valid", W'(rsp_valid), W'(0));
    check("reset_rsp_result", rsp_result, '0);
    check("reset_busy_ready", W'({busy, req_ready}), W'(2'b01));
    check("reset_alu_bus", W'(alu_sel) | alu_a | alu_b, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Logic/arith ops, single-cycle latency.
    run_op(OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1, "or");
    run_op(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, "sub_wrap");
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, "slt_signed");
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "add_wrap");
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, "and");

    // Iterative MUL.
    run_op(OP_MUL, 32'd7,         32'd6,         32'd42,        3,  "mul_7x6");
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, "mul_ones");
    run_op(OP_MUL, 32'h0000_1234, 32'd0,         32'd0,         1,  "mul_by0");
    run_op(OP_MUL, 32'h0001_0003, 32'h0000_0105, 32'h0105_030F, 9,  "mul_mixed");

    // Backpressure: held req_valid must not be accepted while the response is stalled.
    wait_idle();
    rsp_ready = 1'b0;
    exp_q.push_back(32'd30);
    name_q.push_back("bp_rsp");
    req_op    = OP_ADD;
    req_a     = 32'd10;
    req_b     = 32'd20;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_op = OP_SUB;
    req_a  = 32'd99;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", W'(rsp_valid), W'(1));
      check("bp_result", rsp_result, 32'd30);
      check("bp_ready_low", W'(req_ready), W'(0));
      check("bp_alu_sel_idle", W'(alu_sel), W'(0));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after", W'({busy, req_ready, rsp_valid}), W'(3'b010));

    // Reset in the middle of a long MUL: no response may appear.
    req_op    = OP_MUL;
    req_a     = 32'd3;
    req_b     = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("mid_mul_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", W'(rsp_valid), W'(0));
    check("rst_mid_result", rsp_result, '0);
    check("rst_mid_busy_ready", W'({busy, req_ready}), W'(2'b01));
    check("rst_mid_alu_bus", W'(alu_sel) | alu_a | alu_b, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_rst");

    // Back-to-back with req_valid held: second accept on the edge after the handshake.
    wait_idle();
    exp_q.push_back(32'hF00F_F00F);
    name_q.push_back("b2b_xor");
    exp_q.push_back(32'hFF00_0000);
    name_q.push_back("b2b_nor");
    req_op    = OP_XOR;
    req_a     = 32'hFF00_FF00;
    req_b     = 32'h0F0F_0F0F;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_op = OP_NOR;
    req_a  = 32'h0000_FFFF;
    req_b  = 32'h00FF_0000;
    @(posedge clk);
    #1;
    check("b2b_first_done", W'(rsp_valid), W'(1));
    @(posedge clk);
    #1;
    check("b2b_idle_gap", W'({busy, req_ready}), W'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b_second_accept", W'(busy), W'(1));
    check("b2b_second_sel", W'(alu_sel), W'(OP_NOR));
    wait_idle();

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
